// File: rtl/uart_rx_4byte_if.sv
// Serial RX line plus the assembled-word / strobe bundle of the 4-byte UART receiver.
// Receiver side uses master; the consumer (and line driver) uses slave.
interface uart_rx_4byte_if;
   logic        uart_rx_d;
   logic [31:0] uart_rx_data;
   logic        uart_rx_done;
   logic        uart_rx_err;
   logic        uart_rx_busy;

   modport master (
      input  uart_rx_d,
      output uart_rx_data,
      output uart_rx_done,
      output uart_rx_err,
      output uart_rx_busy
   );

   modport slave (
      output uart_rx_d,
      input  uart_rx_data,
      input  uart_rx_done,
      input  uart_rx_err,
      input  uart_rx_busy
   );
endinterface

// File: rtl/uart_rx_4byte.sv
// Deserialises four 8N1 frames into one 32-bit word (first byte in [31:24]); done 1 cycle after mid-stop of byte 4.
// No backpressure: done/err are single-cycle strobes and uart_rx_data holds until the next complete word.
module uart_rx_4byte #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int UART_BAUD = 115200,
   parameter int GAP_BITS  = 20
) (
   input  logic            clk,
   input  logic            rst,
   uart_rx_4byte_if.master rx
);
   localparam int BAUD_CNT = CLK_FREQ / UART_BAUD;
   localparam int HALF_CNT = BAUD_CNT / 2;
   localparam int GAP_LIM  = GAP_BITS * BAUD_CNT;
   localparam int CNT_W    = $clog2(BAUD_CNT);
   localparam int GAP_W    = $clog2(GAP_LIM);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t             state, state_nxt;
   logic               rx_s1, rx_s2, rx_s3;
   logic               fall, mid;
   logic [CNT_W-1:0]   baud_cnt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift;
   logic [23:0]        word;
   logic [1:0]         byte_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic               bit_take, byte_ok, frame_err;

   assign fall = rx_s3 & ~rx_s2;
   assign mid  = (baud_cnt == CNT_W'(HALF_CNT - 1));
   assign rx.uart_rx_busy = (state != IDLE);

   always_comb begin
      state_nxt = state;
      bit_take  = 1'b0;
      byte_ok   = 1'b0;
      frame_err = 1'b0;
      case (state)
         IDLE:      if (fall) state_nxt = START;
         START:     if (mid) state_nxt = rx_s2 ? IDLE : DATA;
         DATA: begin
            if (mid) begin
               bit_take = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (mid) begin
               if (rx_s2) begin
                  byte_ok   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  frame_err = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: if (rx_s2) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         rx_s1           <= 1'b1;
         rx_s2           <= 1'b1;
         rx_s3           <= 1'b1;
         baud_cnt        <= '0;
         bit_cnt         <= '0;
         shift           <= '0;
         word            <= '0;
         byte_cnt        <= '0;
         gap_cnt         <= '0;
         rx.uart_rx_data <= '0;
         rx.uart_rx_done <= 1'b0;
         rx.uart_rx_err  <= 1'b0;
      end else begin
         state           <= state_nxt;
         rx_s1           <= rx.uart_rx_d;
         rx_s2           <= rx_s1;
         rx_s3           <= rx_s2;
         rx.uart_rx_done <= 1'b0;
         rx.uart_rx_err  <= frame_err;

         // Free-running mod-BAUD_CNT count from the start edge keeps every sample at mid-bit.
         if (state == IDLE || state == WAIT_HIGH || baud_cnt == CNT_W'(BAUD_CNT - 1))
            baud_cnt <= '0;
         else
            baud_cnt <= baud_cnt + 1'b1;

         if (bit_take) begin
            shift   <= {rx_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end

         if (byte_ok) begin
            word <= {word[15:0], shift};
            if (byte_cnt == 2'd3) begin
               rx.uart_rx_data <= {word, shift};
               rx.uart_rx_done <= 1'b1;
               byte_cnt        <= '0;
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
            end
         end

         if (frame_err) byte_cnt <= '0;

         // Inter-byte timeout; only runs in IDLE so it never collides with byte_ok/frame_err.
         if (fall || byte_cnt == 2'd0) begin
            gap_cnt <= '0;
         end else if (state == IDLE) begin
            if (gap_cnt == GAP_W'(GAP_LIM - 1)) begin
               gap_cnt  <= '0;
               byte_cnt <= '0;
            end else begin
               gap_cnt <= gap_cnt + 1'b1;
            end
         end
      end
   end
endmodule
